module_div_calc: RTL and testbench
==================================

# module_div_calc

Keypad-driven decimal calculator core: collects up to NDIG decimal digits per operand from debounced key strobes, then runs a WIDTH-cycle sequential restoring division. It sits between the keypad reader and the display path. It replaces the fixed 4-bit operand registers, entry FSM and combinational divider with one parametrised block. Outputs binary quotient/remainder plus BCD operand digits and a display-mode select for the 7-segment mux.

## Interface
- NDIG, 2, decimal digits per operand (1..4)
- WIDTH, 7, operand/result bit width; requires 2**WIDTH > 10**NDIG - 1
- clk  in  1  system clock; all logic in this single domain
- rst_in  in  1  asynchronous, active-low reset
- press  in  1  single-cycle key strobe, already debounced
- numero  in  4  key code qualified by press
- a_bcd  out  4*NDIG  entered A digits, most significant nibble first
- b_bcd  out  4*NDIG  entered B digits, same format
- q  out  WIDTH  quotient
- r  out  WIDTH  remainder
- busy  out  1  division in progress
- done  out  1  one-cycle pulse when q/r/err become valid
- err  out  1  division by zero on last result
- sel_disp  out  1  0 = show operands, 1 = show result

## Operation
- Key codes: 0x0-0x9 digit; 0xA ENTER; 0xC CLEAR; all others ignored.
- States: S_A (entering A), S_B (entering B), S_DIV (dividing), S_SHOW (result held).
- Digit in S_A/S_B: if fewer than NDIG digits are held, acc <= acc*10 + digit and the BCD register shifts left by one nibble, inserting the digit. If NDIG digits are already held, the digit is ignored.
- ENTER in S_A -> S_B. ENTER in S_B -> S_DIV; an operand with zero digits entered is 0.
- S_DIV: restoring division, one quotient bit per cycle, MSB first, exactly WIDTH iterations. Then -> S_SHOW with a done pulse.
- Divide by zero: no iterations. Next cycle q = all ones, r = A, err = 1, done pulses, state -> S_SHOW.
- S_SHOW: a digit key clears A, B, q, r and err, loads the digit as A's first digit and -> S_A. ENTER is ignored.
- CLEAR in any state, including S_DIV: zero A, B, digit counts, q, r and err, abort any division, go to S_A. No done pulse.
- Keys other than CLEAR are ignored during S_DIV.
- sel_disp = 1 only in S_SHOW. busy = 1 only in S_DIV.
- Arithmetic: accumulation is unsigned and never overflows, given the parameter constraint. Quotient/remainder are unsigned WIDTH-bit values, with r < B when B != 0.

## Timing
- Reset (rst_in low, asynchronous): state S_A; a_bcd, b_bcd, q, r = 0; busy, done, err, sel_disp = 0.
- Register updates on the clk edge where press is sampled high; outputs reflect it the following cycle.
- ENTER in S_B sampled at edge t: busy = 1 from t+1, done = 1 for the single cycle t+WIDTH+1.
- At that cycle q/r/err are final, busy = 0 and sel_disp = 1. Values hold until CLEAR, a new digit, or reset.
- Divide by zero: done in cycle t+1.
- q and r are not guaranteed meaningful while busy = 1.
- Back-to-back presses on consecutive cycles are each processed.
- Reset asserted mid-division aborts immediately; no done pulse after release.

## Structure
- Package div_calc_pkg: state enum (S_A, S_B, S_DIV, S_SHOW), key code constants KEY_ENTER = 4'hA and KEY_CLEAR = 4'hC, and the function for the bits required by NDIG.
- Sub-module module_seq_divider: WIDTH-parametrised restoring divider.
  - Ports: clk, rst_in, start, abort, dividend, divisor, busy, done, q, r, dz.
  - The top FSM owns entry logic and the BCD/binary accumulators.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan
- NDIG=2, WIDTH=7: keys 8,7,A,5,A -> a_bcd = 0x87, b_bcd = 0x05. Done 8 cycles after the second ENTER with q = 17, r = 2, err = 0, sel_disp = 1.
- Keys 9,A,0,A -> done 1 cycle after ENTER, err = 1, q = 127, r = 9.
- Keys 1,2,3,A,4,A -> third digit ignored: a_bcd = 0x12; result q = 3, r = 0.
- Keys 9,9,A,1,A, then CLEAR three cycles later -> busy drops next cycle, no done pulse, all outputs 0, state S_A.
- From S_SHOW after 87/5: key 6 -> a_bcd = 0x06, b_bcd = 0, q = r = 0, sel_disp = 0. Then B,F are ignored, and A,3,A gives q = 2, r = 0.
- rst_in pulsed low asynchronously mid-entry and mid-division -> all outputs take reset values at once. The next full entry 50/7 gives q = 7, r = 1.

Source files
------------

// File: rtl/div_calc_pkg.sv
// Shared definitions for the keypad divider calculator.
//   state_e   : entry / divide / show sequencing states
//   KEY_*     : keypad control codes
//   min_width : smallest binary width that holds any NDIG-digit decimal value
package div_calc_pkg;

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_DIV,
        S_SHOW
    } state_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    function automatic int unsigned min_width(input int unsigned ndig);
        int unsigned pow10;
        pow10 = 1;
        for (int unsigned i = 0; i < ndig; i++) begin
            pow10 = pow10 * 10;
        end
        // pow10 is never a power of two, so 2**clog2(pow10) > pow10 - 1
        return $clog2(pow10);
    endfunction

endpackage

// File: rtl/module_seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst_in : clock, asynchronous active-low reset
//   start       : begin a division with dividend/divisor (ignored while busy)
//   abort       : cancel any running division, no done
//   dividend    : numerator, sampled on start
//   divisor     : denominator, sampled on start
//   busy        : iterations in progress
//   done        : strobe, high in the cycle whose clock edge completes the
//                 result; q/r/dz are valid alongside it
//   q, r, dz    : result presented with done (dz = divide by zero)
// A zero divisor completes on the start edge itself: q = all ones, r = dividend.
module module_seq_divider #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   trial;
    logic             last;
    logic             dz_hit;
    logic             load;

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, dvs_q}) begin
            // difference is below dvs_q, so the low WIDTH bits are exact
            rem_d = trial[WIDTH-1:0] - dvs_q;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign last   = busy_q && (cnt_q == CW'(1));
    assign dz_hit = start && !busy_q && (divisor == '0);
    assign load   = start && !busy_q && (divisor != '0);

    assign busy = busy_q;
    assign done = !abort && (last || dz_hit);
    assign dz   = dz_hit;
    assign q    = dz_hit ? '1 : quo_d;
    assign r    = dz_hit ? dividend : rem_d;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (load) begin
            busy_q <= 1'b1;
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= CW'(WIDTH);
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/module_div_calc.sv
// Keypad-driven decimal divide calculator core.
//   clk, rst_in : clock, asynchronous active-low reset
//   press       : single-cycle debounced key strobe
//   numero      : key code (0-9 digit, A enter, C clear) qualified by press
//   a_bcd/b_bcd : entered operand digits, most significant nibble first
//   q, r        : quotient / remainder of the last division
//   busy        : division running
//   done        : one-cycle pulse when q/r/err become valid
//   err         : last division was by zero
//   sel_disp    : 0 shows operands, 1 shows result
module module_div_calc
    import div_calc_pkg::*;
#(
    parameter int unsigned NDIG  = 2,
    parameter int unsigned WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              press,
    input  logic [3:0]        numero,
    output logic [4*NDIG-1:0] a_bcd,
    output logic [4*NDIG-1:0] b_bcd,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  r,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sel_disp
);

    localparam int unsigned CB = $clog2(NDIG + 1);
    localparam int unsigned BW = 4 * NDIG;

    if (NDIG < 1 || NDIG > 4 || WIDTH < min_width(NDIG)) begin : g_param_check
        $error("module_div_calc: NDIG must be 1..4 and WIDTH must hold 10**NDIG-1");
    end

    state_e           state_q;
    logic [WIDTH-1:0] acc_a_q, acc_b_q;
    logic [WIDTH-1:0] acc_a_d, acc_b_d;
    logic [BW-1:0]    bcd_a_q, bcd_b_q;
    logic [BW-1:0]    bcd_a_d, bcd_b_d;
    logic [CB-1:0]    cnt_a_q, cnt_b_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic             err_q, done_q;

    logic             is_digit, key_enter, key_clear;
    logic             div_start, div_busy, div_done, div_dz;
    logic [WIDTH-1:0] div_q, div_r;

    assign is_digit  = press && (numero <= 4'd9);
    assign key_enter = press && (numero == KEY_ENTER);
    assign key_clear = press && (numero == KEY_CLEAR);
    assign div_start = key_enter && (state_q == S_B);

    // acc*10 + digit as shifts; no overflow given the WIDTH check above
    assign acc_a_d = (acc_a_q << 3) + (acc_a_q << 1) + WIDTH'(numero);
    assign acc_b_d = (acc_b_q << 3) + (acc_b_q << 1) + WIDTH'(numero);
    assign bcd_a_d = (bcd_a_q << 4) | BW'(numero);
    assign bcd_b_d = (bcd_b_q << 4) | BW'(numero);

    module_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst_in   (rst_in),
        .start    (div_start),
        .abort    (key_clear),
        .dividend (acc_a_q),
        .divisor  (acc_b_q),
        .busy     (div_busy),
        .done     (div_done),
        .q        (div_q),
        .r        (div_r),
        .dz       (div_dz)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_A;
            acc_a_q <= '0;
            acc_b_q <= '0;
            bcd_a_q <= '0;
            bcd_b_q <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (key_clear) begin
                state_q <= S_A;
                acc_a_q <= '0;
                acc_b_q <= '0;
                bcd_a_q <= '0;
                bcd_b_q <= '0;
                cnt_a_q <= '0;
                cnt_b_q <= '0;
                q_q     <= '0;
                r_q     <= '0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (is_digit) begin
                            if (cnt_a_q < CB'(NDIG)) begin
                                acc_a_q <= acc_a_d;
                                bcd_a_q <= bcd_a_d;
                                cnt_a_q <= cnt_a_q + CB'(1);
                            end
                        end else if (key_enter) begin
                            state_q <= S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (cnt_b_q < CB'(NDIG)) begin
                                acc_b_q <= acc_b_d;
                                bcd_b_q <= bcd_b_d;
                                cnt_b_q <= cnt_b_q + CB'(1);
                            end
                        end else if (key_enter) begin
                            // divide by zero completes on this same edge
                            if (div_done) begin
                                q_q     <= div_q;
                                r_q     <= div_r;
                                err_q   <= div_dz;
                                done_q  <= 1'b1;
                                state_q <= S_SHOW;
                            end else begin
                                state_q <= S_DIV;
                            end
                        end
                    end
                    S_DIV: begin
                        if (div_done) begin
                            q_q     <= div_q;
                            r_q     <= div_r;
                            err_q   <= div_dz;
                            done_q  <= 1'b1;
                            state_q <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (is_digit) begin
                            acc_a_q <= WIDTH'(numero);
                            bcd_a_q <= BW'(numero);
                            cnt_a_q <= CB'(1);
                            acc_b_q <= '0;
                            bcd_b_q <= '0;
                            cnt_b_q <= '0;
                            q_q     <= '0;
                            r_q     <= '0;
                            err_q   <= 1'b0;
                            state_q <= S_A;
                        end
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign a_bcd    = bcd_a_q;
    assign b_bcd    = bcd_b_q;
    assign q        = q_q;
    assign r        = r_q;
    assign err      = err_q;
    assign done     = done_q;
    assign busy     = div_busy;
    assign sel_disp = (state_q == S_SHOW);

endmodule

// File: tb/tb_module_div_calc.sv
// Self-checking bench for module_div_calc (NDIG=2, WIDTH=7).
module tb_module_div_calc;
    import div_calc_pkg::*;

    localparam int unsigned NDIG  = 2;
    localparam int unsigned WIDTH = 7;

    logic                clk;
    logic                rst_in;
    logic                press;
    logic [3:0]          numero;
    logic [4*NDIG-1:0]   a_bcd, b_bcd;
    logic [WIDTH-1:0]    q, r;
    logic                busy, done, err, sel_disp;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    typedef struct {
        int q;
        int r;
        int err;
        int cyc;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    module_div_calc #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .press    (press),
        .numero   (numero),
        .a_bcd    (a_bcd),
        .b_bcd    (b_bcd),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sel_disp (sel_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // called at a negedge; the key is sampled on the next posedge
    task automatic key(input logic [3:0] k);
        press  = 1'b1;
        numero = k;
        @(negedge clk);
        press  = 1'b0;
        numero = 4'h0;
    endtask

    task automatic enter_num(input int v);
        if (v >= 10) key(4'(v / 10));
        if (v > 0) key(4'(v % 10));
    endtask

    task automatic push_exp(input int qv, input int rv, input int ev, input int lat);
        exp_t e;
        e.q   = qv;
        e.r   = rv;
        e.err = ev;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * WIDTH && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("done_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        key(KEY_CLEAR);
        enter_num(v.a);
        key(KEY_ENTER);
        chk("a_bcd_entry", a_bcd, to_bcd(v.a));
        enter_num(v.b);
        chk("b_bcd_entry", b_bcd, to_bcd(v.b));
        push_exp(v.q, v.r, v.err, (v.b == 0) ? 0 : WIDTH);
        key(KEY_ENTER);
        wait_done();
        chk("a_bcd_hold", a_bcd, to_bcd(v.a));
        chk("b_bcd_hold", b_bcd, to_bcd(v.b));
        chk("sel_disp_hold", sel_disp, 1);
        chk("q_hold", q, v.q);
        chk("r_hold", r, v.r);
    endtask

    // scoreboard: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst_in && done) begin
            n_done++;
            chk("done_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("q", q, mon_e.q);
                chk("r", r, mon_e.r);
                chk("err", err, mon_e.err);
                chk("sel_disp_at_done", sel_disp, 1);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        rst_in = 1'b0;
        press  = 1'b0;
        numero = 4'h0;

        vecs[0] = '{a: 87, b: 5,  q: 17,  r: 2, err: 0};
        vecs[1] = '{a: 9,  b: 0,  q: 127, r: 9, err: 1};
        vecs[2] = '{a: 99, b: 1,  q: 99,  r: 0, err: 0};
        vecs[3] = '{a: 50, b: 7,  q: 7,   r: 1, err: 0};
        vecs[4] = '{a: 0,  b: 3,  q: 0,   r: 0, err: 0};
        vecs[5] = '{a: 99, b: 99, q: 1,   r: 0, err: 0};
        vecs[6] = '{a: 1,  b: 99, q: 0,   r: 1, err: 0};
        vecs[7] = '{a: 64, b: 10, q: 6,   r: 4, err: 0};
        vecs[8] = '{a: 0,  b: 0,  q: 127, r: 0, err: 1};
        vecs[9] = '{a: 98, b: 7,  q: 14,  r: 0, err: 0};

        #3;
        chk("rst_a_bcd", a_bcd, 0);
        chk("rst_b_bcd", b_bcd, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sel_disp", sel_disp, 0);
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // third digit ignored
        key(KEY_CLEAR);
        key(4'd1); key(4'd2); key(4'd3);
        chk("three_digit_a_bcd", a_bcd, 8'h12);
        key(KEY_ENTER);
        key(4'd4);
        push_exp(3, 0, 0, WIDTH);
        key(KEY_ENTER);
        wait_done();

        // S_SHOW: ENTER ignored, digit restarts entry, junk keys ignored
        run_vec(vecs[0]);
        key(KEY_ENTER);
        chk("show_enter_sel_disp", sel_disp, 1);
        chk("show_enter_q", q, 17);
        key(4'd6);
        chk("restart_a_bcd", a_bcd, 8'h06);
        chk("restart_b_bcd", b_bcd, 0);
        chk("restart_q", q, 0);
        chk("restart_r", r, 0);
        chk("restart_sel_disp", sel_disp, 0);
        key(4'hB); key(4'hF);
        chk("junk_a_bcd", a_bcd, 8'h06);
        chk("junk_sel_disp", sel_disp, 0);
        key(KEY_ENTER);
        key(4'd3);
        push_exp(2, 0, 0, WIDTH);
        key(KEY_ENTER);
        wait_done();

        // keys other than CLEAR ignored while dividing
        key(KEY_CLEAR);
        key(4'd8); key(4'd4); key(KEY_ENTER); key(4'd4);
        push_exp(21, 0, 0, WIDTH);
        key(KEY_ENTER);
        key(4'd5);
        key(KEY_ENTER);
        chk("div_busy_mid", busy, 1);
        chk("div_ignore_a_bcd", a_bcd, 8'h84);
        chk("div_ignore_b_bcd", b_bcd, 8'h04);
        wait_done();

        // CLEAR three cycles into a division
        d0 = n_done;
        key(KEY_CLEAR);
        key(4'd9); key(4'd9); key(KEY_ENTER); key(4'd1);
        key(KEY_ENTER);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        key(KEY_CLEAR);
        chk("abort_busy", busy, 0);
        chk("abort_a_bcd", a_bcd, 0);
        chk("abort_b_bcd", b_bcd, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_sel_disp", sel_disp, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done, d0);

        // CLEAR wipes an error result
        key(4'd7); key(KEY_ENTER);
        push_exp(127, 7, 1, 0);
        key(KEY_ENTER);
        wait_done();
        key(KEY_CLEAR);
        chk("clear_err", err, 0);
        chk("clear_q", q, 0);
        chk("clear_r", r, 0);
        chk("clear_sel_disp", sel_disp, 0);

        // asynchronous reset mid-entry
        key(4'd4); key(4'd5);
        chk("pre_reset_a_bcd", a_bcd, 8'h45);
        #2 rst_in = 1'b0;
        #1;
        chk("areset_entry_a_bcd", a_bcd, 0);
        chk("areset_entry_sel_disp", sel_disp, 0);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);

        // asynchronous reset mid-division
        d0 = n_done;
        key(4'd9); key(4'd9); key(KEY_ENTER); key(4'd3);
        key(KEY_ENTER);
        @(negedge clk);
        chk("areset_div_busy_before", busy, 1);
        #2 rst_in = 1'b0;
        #1;
        chk("areset_div_busy", busy, 0);
        chk("areset_div_a_bcd", a_bcd, 0);
        chk("areset_div_b_bcd", b_bcd, 0);
        chk("areset_div_q", q, 0);
        @(negedge clk);
        rst_in = 1'b1;
        repeat (12) @(negedge clk);
        chk("areset_no_done", n_done, d0);

        key(4'd5); key(4'd0); key(KEY_ENTER); key(4'd7);
        push_exp(7, 1, 0, WIDTH);
        key(KEY_ENTER);
        wait_done();
        chk("post_reset_a_bcd", a_bcd, 8'h50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
